// File: rtl/bexkat1Def.sv
// -----------------------------------------------------------------------------
// bexkat1Def -- shared definitions for the pipeline control block.
//   pipe_state_t   : controller state encoding (also visible on state_o)
//   PC_SEQ/PC_BRANCH/PC_EXC : pc_sel encodings for the PC source mux
//   MEMWAIT_LIMIT  : data-bus wait cycles tolerated before a bus error
//   DRAIN_CYCLES   : pipeline drain cycles between exception entry and vector
// -----------------------------------------------------------------------------
package bexkat1Def;

   typedef enum logic [2:0] {
      S_RUN       = 3'd0,
      S_EXC_DRAIN = 3'd1,
      S_EXC_VEC   = 3'd2,
      S_BUSERR    = 3'd3
   } pipe_state_t;

   localparam logic [1:0] PC_SEQ    = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_EXC    = 2'd2;

   localparam int WAIT_W  = 8;
   localparam int DRAIN_W = 2;

   localparam logic [WAIT_W-1:0]  MEMWAIT_LIMIT = 8'd255;
   localparam logic [DRAIN_W-1:0] DRAIN_CYCLES  = 2'd2;

endpackage

// File: rtl/pipe_timeout.sv
// -----------------------------------------------------------------------------
// pipe_timeout -- data-bus wait watchdog.
// Counts consecutive mem_wait cycles and flags the cycle in which the count
// has already reached MEMWAIT_LIMIT while the bus is still stalled.
//   clk_i     in  clock
//   rst_i     in  synchronous active-high reset (clears the count)
//   mem_wait  in  data bus is stalled this cycle
//   limit_hit out stall has lasted past MEMWAIT_LIMIT cycles
// -----------------------------------------------------------------------------
module pipe_timeout
   import bexkat1Def::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic mem_wait,
   output logic limit_hit
);

   logic [WAIT_W-1:0] wait_cnt;

   // The count wraps to 0 on the limit cycle, so a bus that stays stuck
   // re-arms the timeout instead of saturating.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of its inputs.
      if (rst_i) begin
         wait_cnt <= '0;
      end else if (mem_wait) begin
         wait_cnt <= wait_cnt + 1'b1;
      end else begin
         wait_cnt <= '0;
      end
   end

   assign limit_hit = mem_wait && (wait_cnt == MEMWAIT_LIMIT);

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- 5-stage pipeline sequencing controller.
// Produces register-advance enables, bubble clears and the PC source select
// from hazard, bus, branch and exception requests.
//   clk_i, rst_i            clock, synchronous active-high reset
//   load_stall              load-use hazard stall
//   if_ack_i                instruction fetch complete
//   mem_req, mem_ack_i      MEM stage data-bus request / acknowledge
//   exe_branch              taken branch/jump resolved in EXE
//   exc_req                 exception/interrupt pending (level)
//   pc_en .. memwb_en       pipeline register advance enables
//   ifid_clr, idex_clr      load a NOP into IF/ID, ID/EX (only while enabled)
//   pc_sel                  PC_SEQ / PC_BRANCH / PC_EXC
//   exc_ack                 pulse when the exception vector is taken
//   bus_err                 pulse when a data-bus timeout is reported
//   state_o                 current controller state (debug)
// -----------------------------------------------------------------------------
module pipe_ctrl
   import bexkat1Def::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       load_stall,
   input  logic       if_ack_i,
   input  logic       mem_req,
   input  logic       mem_ack_i,
   input  logic       exe_branch,
   input  logic       exc_req,
   output logic       pc_en,
   output logic       ifid_en,
   output logic       idex_en,
   output logic       exmem_en,
   output logic       memwb_en,
   output logic       ifid_clr,
   output logic       idex_clr,
   output logic [1:0] pc_sel,
   output logic       exc_ack,
   output logic       bus_err,
   output logic [2:0] state_o
);

   pipe_state_t        state, state_nxt;
   logic [DRAIN_W-1:0] drain_cnt, drain_nxt;
   logic               mem_wait;
   logic               limit_hit;

   assign mem_wait = mem_req & ~mem_ack_i;
   assign state_o  = state;

   pipe_timeout u_timeout (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .mem_wait  (mem_wait),
      .limit_hit (limit_hit)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= S_RUN;
         drain_cnt <= '0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_nxt;
      end
   end

   always_comb begin
      // NOTE: every output and next-state variable gets a default first, so
      // no path through the branches below can infer a latch.
      state_nxt = state;
      drain_nxt = drain_cnt;
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      exmem_en  = 1'b0;
      memwb_en  = 1'b0;
      ifid_clr  = 1'b0;
      idex_clr  = 1'b0;
      pc_sel    = PC_SEQ;
      exc_ack   = 1'b0;
      bus_err   = 1'b0;

      if (rst_i) begin
         // Pipeline frozen with bubbles requested; registers reset on the edge.
         ifid_clr = 1'b1;
         idex_clr = 1'b1;
      end else if (mem_wait) begin
         // Whole pipe freezes while the data bus stalls; only a timeout moves on.
         if (limit_hit) begin
            state_nxt = S_BUSERR;
         end
      end else begin
         case (state)
            S_RUN: begin
               pc_en    = 1'b1;
               ifid_en  = 1'b1;
               idex_en  = 1'b1;
               exmem_en = 1'b1;
               memwb_en = 1'b1;
               if (exc_req) begin
                  // Exception wins over a coincident branch: its target is
                  // dropped and the fetched shadow instruction is flushed.
                  pc_en     = 1'b0;
                  ifid_clr  = 1'b1;
                  drain_nxt = DRAIN_CYCLES;
                  state_nxt = S_EXC_DRAIN;
               end else if (exe_branch) begin
                  pc_sel   = PC_BRANCH;
                  ifid_clr = 1'b1;
                  idex_clr = 1'b1;
               end else if (load_stall) begin
                  // Hold PC and IF/ID, inject a bubble into EX.
                  pc_en    = 1'b0;
                  ifid_en  = 1'b0;
                  idex_clr = 1'b1;
               end else if (!if_ack_i) begin
                  pc_en    = 1'b0;
                  ifid_clr = 1'b1;
               end
            end

            S_EXC_DRAIN: begin
               ifid_en  = 1'b1;
               idex_en  = 1'b1;
               exmem_en = 1'b1;
               memwb_en = 1'b1;
               ifid_clr = 1'b1;
               idex_clr = 1'b1;
               if (drain_cnt <= DRAIN_W'(1)) begin
                  drain_nxt = '0;
                  state_nxt = S_EXC_VEC;
               end else begin
                  drain_nxt = drain_cnt - 1'b1;
               end
            end

            S_EXC_VEC: begin
               pc_sel    = PC_EXC;
               pc_en     = 1'b1;
               ifid_en   = 1'b1;
               idex_en   = 1'b1;
               exmem_en  = 1'b1;
               memwb_en  = 1'b1;
               ifid_clr  = 1'b1;
               exc_ack   = 1'b1;
               state_nxt = S_RUN;
            end

            S_BUSERR: begin
               // Retire the faulting access without writing back, flush the
               // front end, then enter the exception drain.
               bus_err   = 1'b1;
               ifid_en   = 1'b1;
               idex_en   = 1'b1;
               exmem_en  = 1'b1;
               ifid_clr  = 1'b1;
               idex_clr  = 1'b1;
               drain_nxt = DRAIN_CYCLES;
               state_nxt = S_EXC_DRAIN;
            end

            default: begin
               state_nxt = S_RUN;
               drain_nxt = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl.
// A behavioural model (exception progress as a remaining-drain count plus
// vector/bus-error flags, bus stall as a run length) predicts every output
// each cycle; directed sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;
   import bexkat1Def::*;

   logic       clk = 1'b0;
   logic       rst, load_stall, if_ack, mem_req, mem_ack, exe_branch, exc_req;
   logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_clr, idex_clr;
   logic [1:0] pc_sel;
   logic       exc_ack, bus_err;
   logic [2:0] state_o;
   logic [13:0] outs;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 1'b0;

   // model state
   int m_wait   = 0;
   int m_drain  = 0;
   bit m_vec    = 1'b0;
   bit m_buserr = 1'b0;

   localparam logic [13:0] NO_STATE = 14'h3ff8;

   always #5 clk = ~clk;

   pipe_ctrl dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_stall (load_stall),
      .if_ack_i   (if_ack),
      .mem_req    (mem_req),
      .mem_ack_i  (mem_ack),
      .exe_branch (exe_branch),
      .exc_req    (exc_req),
      .pc_en      (pc_en),
      .ifid_en    (ifid_en),
      .idex_en    (idex_en),
      .exmem_en   (exmem_en),
      .memwb_en   (memwb_en),
      .ifid_clr   (ifid_clr),
      .idex_clr   (idex_clr),
      .pc_sel     (pc_sel),
      .exc_ack    (exc_ack),
      .bus_err    (bus_err),
      .state_o    (state_o)
   );

   assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                  ifid_clr, idex_clr, pc_sel, exc_ack, bus_err, state_o};

   task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s @%0t: got %b expected %b (en5 clr2 sel2 ack berr st3)",
                  name, $time, act, exp);
      end
   endtask

   function automatic logic [13:0] pk(input logic [4:0] en, input logic [1:0] clr,
                                      input logic [1:0] sel, input logic ack,
                                      input logic berr, input pipe_state_t st);
      return {en, clr, sel, ack, berr, st};
   endfunction

   // Expected outputs for the current cycle from the model and live inputs.
   function automatic logic [13:0] model_expect();
      logic [4:0]  en;
      logic [1:0]  clr, sel;
      logic        ack, berr;
      pipe_state_t st;
      en = '0; clr = '0; sel = 2'd0; ack = 1'b0; berr = 1'b0;
      if (m_buserr)        st = S_BUSERR;
      else if (m_vec)      st = S_EXC_VEC;
      else if (m_drain > 0) st = S_EXC_DRAIN;
      else                 st = S_RUN;

      if (rst) begin
         clr = 2'b11;
      end else if (mem_req && !mem_ack) begin
         en = 5'b00000;      // frozen
      end else if (m_buserr) begin
         en = 5'b01110; clr = 2'b11; berr = 1'b1;
      end else if (m_vec) begin
         en = 5'b11111; clr = 2'b10; sel = 2'd2; ack = 1'b1;
      end else if (m_drain > 0) begin
         en = 5'b01111; clr = 2'b11;
      end else if (exc_req) begin
         en = 5'b01111; clr = 2'b10;
      end else if (exe_branch) begin
         en = 5'b11111; clr = 2'b11; sel = 2'd1;
      end else if (load_stall) begin
         en = 5'b00111; clr = 2'b01;
      end else if (!if_ack) begin
         en = 5'b01111; clr = 2'b10;
      end else begin
         en = 5'b11111;
      end
      return {en, clr, sel, ack, berr, st};
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_wait   <= 0;
         m_drain  <= 0;
         m_vec    <= 1'b0;
         m_buserr <= 1'b0;
      end else if (mem_req && !mem_ack) begin
         if (m_wait == 255) begin
            m_buserr <= 1'b1;
            m_vec    <= 1'b0;
            m_drain  <= 0;
            m_wait   <= 0;
         end else begin
            m_wait <= m_wait + 1;
         end
      end else begin
         m_wait <= 0;
         if (m_buserr) begin
            m_buserr <= 1'b0;
            m_drain  <= 2;
         end else if (m_vec) begin
            m_vec <= 1'b0;
         end else if (m_drain > 0) begin
            m_drain <= m_drain - 1;
            if (m_drain == 1) m_vec <= 1'b1;
         end else if (exc_req) begin
            m_drain <= 2;
         end
      end
   end

   // Per-cycle comparison against the model; state is checked once reset is
   // released because the synchronous reset only lands on the edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         if (rst) check("model_rst", outs & NO_STATE, model_expect() & NO_STATE);
         else     check("model", outs, model_expect());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string name, input logic [13:0] exp, input bit mask_state = 1'b0);
      @(negedge clk);
      if (mask_state) check(name, outs & NO_STATE, exp & NO_STATE);
      else            check(name, outs, exp);
      tick();
   endtask

   task automatic idle_inputs();
      rst = 1'b0; load_stall = 1'b0; if_ack = 1'b1; mem_req = 1'b0;
      mem_ack = 1'b0; exe_branch = 1'b0; exc_req = 1'b0;
   endtask

   localparam logic [4:0] EN_ALL = 5'b11111;

   initial begin
      idle_inputs();
      rst = 1'b1;
      tick();
      cmp_en = 1'b1;
      lit("reset", pk(5'b00000, 2'b11, 2'd0, 1'b0, 1'b0, S_RUN));
      rst = 1'b0;
      lit("idle", pk(EN_ALL, 2'b00, 2'd0, 1'b0, 1'b0, S_RUN));

      // load stall for one cycle
      load_stall = 1'b1;
      lit("load_stall", pk(5'b00111, 2'b01, 2'd0, 1'b0, 1'b0, S_RUN));
      load_stall = 1'b0;
      lit("after_stall", pk(EN_ALL, 2'b00, 2'd0, 1'b0, 1'b0, S_RUN));

      // taken branch
      exe_branch = 1'b1;
      lit("branch", pk(EN_ALL, 2'b11, 2'd1, 1'b0, 1'b0, S_RUN));
      exe_branch = 1'b0;
      lit("after_branch", pk(EN_ALL, 2'b00, 2'd0, 1'b0, 1'b0, S_RUN));

      // fetch wait
      if_ack = 1'b0;
      lit("fetch_wait", pk(5'b01111, 2'b10, 2'd0, 1'b0, 1'b0, S_RUN));
      if_ack = 1'b1;

      // exception held high through the whole sequence
      exc_req = 1'b1;
      lit("exc_entry", pk(5'b01111, 2'b10, 2'd0, 1'b0, 1'b0, S_RUN));
      lit("exc_drain1", pk(5'b01111, 2'b11, 2'd0, 1'b0, 1'b0, S_EXC_DRAIN));
      lit("exc_drain2", pk(5'b01111, 2'b11, 2'd0, 1'b0, 1'b0, S_EXC_DRAIN));
      exc_req = 1'b0;
      lit("exc_vec", pk(EN_ALL, 2'b10, 2'd2, 1'b1, 1'b0, S_EXC_VEC));
      lit("exc_done", pk(EN_ALL, 2'b00, 2'd0, 1'b0, 1'b0, S_RUN));

      // bus wait of 10 cycles, no error
      mem_req = 1'b1; mem_ack = 1'b0;
      for (int i = 0; i < 10; i++)
         lit("bus_wait", pk(5'b00000, 2'b00, 2'd0, 1'b0, 1'b0, S_RUN));
      mem_ack = 1'b1;
      lit("bus_ack", pk(EN_ALL, 2'b00, 2'd0, 1'b0, 1'b0, S_RUN));
      mem_req = 1'b0;

      // bus timeout: 256 stalled cycles
      mem_req = 1'b1; mem_ack = 1'b0;
      for (int i = 0; i < 256; i++) begin
         if (i == 0 || i == 255)
            lit("timeout_wait", pk(5'b00000, 2'b00, 2'd0, 1'b0, 1'b0, S_RUN));
         else
            tick();
      end
      mem_req = 1'b0;
      lit("buserr", pk(5'b01110, 2'b11, 2'd0, 1'b0, 1'b1, S_BUSERR));
      lit("buserr_drain1", pk(5'b01111, 2'b11, 2'd0, 1'b0, 1'b0, S_EXC_DRAIN));
      lit("buserr_drain2", pk(5'b01111, 2'b11, 2'd0, 1'b0, 1'b0, S_EXC_DRAIN));
      lit("buserr_vec", pk(EN_ALL, 2'b10, 2'd2, 1'b1, 1'b0, S_EXC_VEC));
      lit("buserr_done", pk(EN_ALL, 2'b00, 2'd0, 1'b0, 1'b0, S_RUN));

      // simultaneous requests: freeze first, then exception only
      exe_branch = 1'b1; load_stall = 1'b1; exc_req = 1'b1;
      mem_req = 1'b1; mem_ack = 1'b0;
      lit("simul_freeze", pk(5'b00000, 2'b00, 2'd0, 1'b0, 1'b0, S_RUN));
      mem_ack = 1'b1;
      lit("simul_entry", pk(5'b01111, 2'b10, 2'd0, 1'b0, 1'b0, S_RUN));
      idle_inputs();
      lit("simul_drain1", pk(5'b01111, 2'b11, 2'd0, 1'b0, 1'b0, S_EXC_DRAIN));
      lit("simul_drain2", pk(5'b01111, 2'b11, 2'd0, 1'b0, 1'b0, S_EXC_DRAIN));
      lit("simul_vec", pk(EN_ALL, 2'b10, 2'd2, 1'b1, 1'b0, S_EXC_VEC));

      // reset pulse in the middle of a drain
      exc_req = 1'b1;
      lit("rst_entry", pk(5'b01111, 2'b10, 2'd0, 1'b0, 1'b0, S_RUN));
      exc_req = 1'b0;
      lit("rst_drain1", pk(5'b01111, 2'b11, 2'd0, 1'b0, 1'b0, S_EXC_DRAIN));
      rst = 1'b1;
      lit("rst_mid_drain", pk(5'b00000, 2'b11, 2'd0, 1'b0, 1'b0, S_RUN), 1'b1);
      rst = 1'b0;
      for (int i = 0; i < 4; i++)
         lit("rst_after", pk(EN_ALL, 2'b00, 2'd0, 1'b0, 1'b0, S_RUN));

      // randomized traffic, checked by the model every cycle
      for (int i = 0; i < 3000; i++) begin
         rst        = ($urandom_range(0, 99) == 0);
         mem_req    = ($urandom_range(0, 3) == 0);
         mem_ack    = $urandom_range(0, 1) == 1;
         exc_req    = ($urandom_range(0, 9) == 0);
         exe_branch = ($urandom_range(0, 4) == 0);
         load_stall = ($urandom_range(0, 4) == 0);
         if_ack     = ($urandom_range(0, 3) != 0);
         tick();
      end

      idle_inputs();
      repeat (6) tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
